// File: rtl/bcd_countdown_ctrl_pkg.sv
// Shared definitions for the BCD countdown controller.
//   state_t   : FSM state encodings (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   BCD_MAX   : largest legal BCD digit
//   bcd_clamp : forces an out-of-range nibble to 9
package bcd_countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_digit.sv
// Single BCD down-counting digit with load and borrow.
//   CLK    : clock
//   RST    : asynchronous active-high reset (Q -> 0)
//   LD     : load LD_VAL (takes priority over EN)
//   LD_VAL : value to load, expected already clamped to 0..9
//   EN     : decrement enable (tick for digit 0, borrow-in otherwise)
//   Q      : current digit
//   BORROW : EN while Q==0, i.e. this digit wraps to 9
module bcd_down_digit
    import bcd_countdown_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       LD,
    input  logic [3:0] LD_VAL,
    input  logic       EN,
    output logic [3:0] Q,
    output logic       BORROW
);

    logic [3:0] r_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= '0;
        end else if (LD) begin
            r_q <= LD_VAL;
        end else if (EN) begin
            r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
        end
    end

    assign Q      = r_q;
    assign BORROW = EN & (r_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Countdown timer core: NDIG cascaded BCD digits, prescaled tick,
// load/start/pause control and a one-cycle DONE pulse at zero.
//   CLK      : clock
//   RST      : asynchronous active-high reset
//   LOAD     : load LOAD_VAL (digits >9 clamped), return to IDLE
//   LOAD_VAL : BCD preset, digit i at [4i+3:4i]
//   START    : start / resume counting
//   PAUSE    : freeze counting (wins over START)
//   CNT      : current BCD value
//   STATE    : FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   RUNNING  : high while STATE==RUN
//   DONE     : one-cycle pulse on entry to DONE
module bcd_countdown_ctrl
    import bcd_countdown_ctrl_pkg::*;
#(
    parameter int NDIG     = 2,
    parameter int TICK_DIV = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD,
    input  logic [4*NDIG-1:0]   LOAD_VAL,
    input  logic                START,
    input  logic                PAUSE,
    output logic [4*NDIG-1:0]   CNT,
    output logic [1:0]          STATE,
    output logic                RUNNING,
    output logic                DONE
);

    localparam int CW = 4 * NDIG;
    localparam int PW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic            r_running;
    logic            r_done;

    logic [CW-1:0]   w_cnt;
    logic [NDIG:0]   w_en;
    logic            w_tick;
    logic            w_cnt_zero;
    logic            w_cnt_one;
    logic            w_unused_borrow;

    // Tick is suppressed by LOAD and PAUSE so the digits never move in a
    // cycle where the FSM leaves RUN or reloads.
    assign w_tick     = (r_state == ST_RUN) && !LOAD && !PAUSE && (r_presc == PRESC_LAST);
    assign w_cnt_zero = (w_cnt == '0);
    assign w_cnt_one  = (w_cnt == CW'(1));

    assign w_en[0] = w_tick;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        bcd_down_digit u_digit (
            .CLK    (CLK),
            .RST    (RST),
            .LD     (LOAD),
            .LD_VAL (bcd_clamp(LOAD_VAL[4*gi +: 4])),
            .EN     (w_en[gi]),
            .Q      (w_cnt[4*gi +: 4]),
            .BORROW (w_en[gi+1])
        );
    end

    // Borrow out of the top digit never fires: RUN ends at value one.
    assign w_unused_borrow = w_en[NDIG];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (LOAD) begin
                r_state   <= ST_IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (START && !PAUSE && !w_cnt_zero) begin
                            r_state   <= ST_RUN;
                            r_presc   <= '0;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (PAUSE) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else begin
                            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
                            if (w_tick && w_cnt_one) begin
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (START && !PAUSE) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CNT     = w_cnt;
    assign STATE   = r_state;
    assign RUNNING = r_running;
    assign DONE    = r_done;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
module tb_bcd_countdown_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD = 1'b0;
    logic [7:0]  LOAD_VAL = '0;
    logic        START = 1'b0;
    logic        PAUSE = 1'b0;
    logic [7:0]  CNT;
    logic [1:0]  STATE;
    logic        RUNNING;
    logic        DONE;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bcd_countdown_ctrl #(.NDIG(2), .TICK_DIV(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .START    (START),
        .PAUSE    (PAUSE),
        .CNT      (CNT),
        .STATE    (STATE),
        .RUNNING  (RUNNING),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        LOAD = 1'b1; LOAD_VAL = v;
        step(1);
        LOAD = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_cnt", 32'(CNT), 32'h00);
        chk("rst_state", 32'(STATE), 32'h0);
        chk("rst_running", 32'(RUNNING), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        #9 RST = 1'b0;
        step(1);

        // Full countdown from 25
        do_load(8'h25);
        chk("load25", 32'(CNT), 32'h25);
        START = 1'b1; step(1); START = 1'b0;            // edge k
        chk("start_state", 32'(STATE), 32'h1);
        chk("start_running", 32'(RUNNING), 32'h1);
        step(3);
        chk("pre_first_tick", 32'(CNT), 32'h25);
        step(1);                                         // k+4
        chk("first_tick", 32'(CNT), 32'h24);
        step(16);                                        // k+20
        chk("cnt20", 32'(CNT), 32'h20);
        step(4);                                         // k+24
        chk("borrow19", 32'(CNT), 32'h19);
        step(75);                                        // k+99
        chk("cnt01", 32'(CNT), 32'h01);
        chk("no_done_yet", 32'(DONE), 32'h0);
        step(1);                                         // k+100
        chk("end_cnt", 32'(CNT), 32'h00);
        chk("end_state", 32'(STATE), 32'h3);
        chk("done_pulse", 32'(DONE), 32'h1);
        chk("end_running", 32'(RUNNING), 32'h0);
        step(1);
        chk("done_once", 32'(DONE), 32'h0);
        chk("done_hold", 32'(STATE), 32'h3);
        START = 1'b1; step(1); START = 1'b0;
        chk("done_start_state", 32'(STATE), 32'h3);
        chk("done_start_cnt", 32'(CNT), 32'h00);

        // Clamp on load
        do_load(8'hA3);
        chk("clamp_a3", 32'(CNT), 32'h93);
        chk("load_idle", 32'(STATE), 32'h0);
        do_load(8'hFF);
        chk("clamp_ff", 32'(CNT), 32'h99);

        // Pause / resume from 10
        do_load(8'h10);
        START = 1'b1; step(1); START = 1'b0;            // edge k, presc 0
        step(2);                                         // presc 2
        PAUSE = 1'b1; step(7);
        chk("pause_cnt", 32'(CNT), 32'h10);
        chk("pause_state", 32'(STATE), 32'h2);
        chk("pause_running", 32'(RUNNING), 32'h0);
        PAUSE = 1'b0; START = 1'b1; step(1); START = 1'b0;
        chk("resume_state", 32'(STATE), 32'h1);
        step(1);
        chk("resume_hold", 32'(CNT), 32'h10);
        step(1);
        chk("resume_tick", 32'(CNT), 32'h09);

        // Simultaneous events
        START = 1'b1; PAUSE = 1'b1; step(1);
        chk("start_pause", 32'(STATE), 32'h2);
        chk("start_pause_cnt", 32'(CNT), 32'h09);
        PAUSE = 1'b0; step(1);
        chk("repause_run", 32'(STATE), 32'h1);
        LOAD = 1'b1; LOAD_VAL = 8'h05; step(1); LOAD = 1'b0; START = 1'b0;
        chk("load_start_cnt", 32'(CNT), 32'h05);
        chk("load_start_state", 32'(STATE), 32'h0);
        chk("load_start_running", 32'(RUNNING), 32'h0);

        // START with zero in IDLE
        do_load(8'h00);
        START = 1'b1; step(1); START = 1'b0;
        chk("zero_start_state", 32'(STATE), 32'h0);
        chk("zero_start_done", 32'(DONE), 32'h0);

        // Asynchronous reset mid-run
        do_load(8'h37);
        START = 1'b1; step(1); START = 1'b0;
        step(5);
        chk("pre_rst_cnt", 32'(CNT), 32'h36);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_cnt", 32'(CNT), 32'h00);
        chk("async_rst_state", 32'(STATE), 32'h0);
        chk("async_rst_running", 32'(RUNNING), 32'h0);
        #1 RST = 1'b0;
        step(10);
        chk("post_rst_cnt", 32'(CNT), 32'h00);
        chk("post_rst_state", 32'(STATE), 32'h0);

        // Short run ends with DONE after 2*TICK_DIV
        do_load(8'h02);
        START = 1'b1; step(1); START = 1'b0;
        step(7);
        chk("short_pre_done", 32'(DONE), 32'h0);
        step(1);
        chk("short_done", 32'(DONE), 32'h1);
        chk("short_state", 32'(STATE), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
